// File: rtl/cobra_mul_pkg.sv
// Shared types and constants for the CYBERcobra multi-cycle multiplier.
// Optional signed mode is enabled by defining COBRA_MUL_SIGNED_EN.
package cobra_mul_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, NEG, DONE} mul_state_t;

    localparam int unsigned MUL_WIDTH = 32;

    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
        return $clog2(width / bpc + 1);
    endfunction

endpackage

// File: rtl/cobra_mul_if.sv
// Core <-> multiplier handshake bundle; sign exists only when COBRA_MUL_SIGNED_EN is defined.
interface cobra_mul_if
    import cobra_mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
);
    logic             req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
`ifdef COBRA_MUL_SIGNED_EN
    logic             sign;
`endif
    logic             stall;
    logic             valid;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    modport master (
        output req, a, b, flush,
`ifdef COBRA_MUL_SIGNED_EN
        output sign,
`endif
        input  stall, valid, result_lo, result_hi
    );

    modport slave (
        input  req, a, b, flush,
`ifdef COBRA_MUL_SIGNED_EN
        input  sign,
`endif
        output stall, valid, result_lo, result_hi
    );
endinterface

// File: rtl/cobra_mul_dp.sv
// Iterative shift-add datapath: multiplicand shifts left, multiplier shifts right,
// accumulator collects partial products; optional final two's-complement negate.
module cobra_mul_dp #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic             negate,
    input  logic             commit,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);
    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    mcand_q, acc_q, res_q, partial;
    logic [WIDTH-1:0] mplier_q, a_mag, b_mag;
    logic             neg_q;

    always_comb begin
        a_mag = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    always_comb begin
        partial = '0;
        for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
            if (mplier_q[j]) partial = partial + (mcand_q << j);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            if (load) begin
                mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                mplier_q <= b_mag;
                acc_q    <= '0;
                neg_q    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (step) begin
                acc_q    <= acc_q + partial;
                mcand_q  <= mcand_q << BITS_PER_CYCLE;
                mplier_q <= mplier_q >> BITS_PER_CYCLE;
            end else if (negate && neg_q) begin
                acc_q <= ~acc_q + 1'b1;
            end
            if (commit) res_q <= acc_q;
        end
    end

    // The fresh product is visible in the DONE cycle itself, then held in res_q.
    assign {result_hi, result_lo} = commit ? acc_q : res_q;

endmodule

// File: rtl/cobra_mul_ctrl.sv
// Multiply sequencer: stalls the core while cobra_mul_dp iterates, strobes valid once.
// Define COBRA_MUL_SIGNED_EN to add the sign input and the NEG fix-up state.
module cobra_mul_ctrl
    import cobra_mul_pkg::*;
#(
    parameter int unsigned WIDTH          = MUL_WIDTH,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic        clk_i,
    input logic        rst_i,
    cobra_mul_if.slave bus
);
    localparam int unsigned ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW    = cnt_width(WIDTH, BITS_PER_CYCLE);

    mul_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          stall, valid, load, step, negate, sign_in;

`ifdef COBRA_MUL_SIGNED_EN
    logic signed_q;
    assign sign_in = bus.sign;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)    signed_q <= 1'b0;
        else if (load) signed_q <= sign_in;
    end
`else
    assign sign_in = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load)      cnt_q <= '0;
            else if (step) cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.req) state_d = BUSY;
            BUSY: begin
                if (cnt_q == CW'(ITERS - 1)) begin
`ifdef COBRA_MUL_SIGNED_EN
                    state_d = signed_q ? NEG : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
            NEG:  state_d = DONE;
            DONE: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // stall in IDLE follows req so the acceptance cycle itself holds the core.
    always_comb begin
        stall  = 1'b0;
        valid  = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        negate = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = bus.req;
                load  = bus.req & ~bus.flush;
            end
            BUSY: begin
                stall = 1'b1;
                step  = ~bus.flush;
            end
            NEG: begin
                stall  = 1'b1;
                negate = ~bus.flush;
            end
            DONE: valid = ~bus.flush;
        endcase
    end

    assign bus.stall = stall;
    assign bus.valid = valid;

    cobra_mul_dp #(
        .WIDTH         (WIDTH),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_dp (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (load),
        .step     (step),
        .negate   (negate),
        .commit   (valid),
        .sign     (sign_in),
        .a        (bus.a),
        .b        (bus.b),
        .result_lo(bus.result_lo),
        .result_hi(bus.result_hi)
    );

endmodule

// File: tb/tb_cobra_mul_ctrl.sv
// Scoreboard bench for cobra_mul_ctrl: driver pushes model products, monitor pops on valid.
module tb_cobra_mul_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cobra_mul_if #(.WIDTH(32)) bus ();

    cobra_mul_ctrl #(
        .WIDTH         (32),
        .BITS_PER_CYCLE(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [63:0] prod;
        int          due;
        int          stall_len;
    } exp_t;

    exp_t sb_q[$];
    int   stall_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sign-extend when signed, multiply, keep 64 bits.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int off);
        exp_t e;
        int   lat;
        lat = sgn ? 34 : 33;
        e.prod = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
        e.due = cyc + off + lat;
        e.stall_len = lat;
        sb_q.push_back(e);
        bus.req = 1'b1;
        bus.a   = a;
        bus.b   = b;
`ifdef COBRA_MUL_SIGNED_EN
        bus.sign = sgn;
`endif
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL valid_timeout: got no valid, expected valid within 100 cycles");
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 15));
            2:       v = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_run = 0;
        end else begin
            if (bus.valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 64'(bus.valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result_lo", 64'(bus.result_lo), 64'(e.prod[31:0]));
                    chk("result_hi", 64'(bus.result_hi), 64'(e.prod[63:32]));
                    chk("latency", 64'(cyc), 64'(e.due));
                    chk("stall_len", 64'(stall_run), 64'(e.stall_len));
                end
            end
            stall_run = (bus.stall === 1'b1) ? stall_run + 1 : 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t1, t2, b2b;
        logic        sgn;
        logic [63:0] last;

        rst_n     = 1'b0;
        bus.req   = 1'b0;
        bus.flush = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef COBRA_MUL_SIGNED_EN
        bus.sign  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.stall, bus.valid, bus.result_hi, bus.result_lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd3, 32'd5, 1'b0, 0);
        wait_valid();
        chk("dir_3x5", {bus.result_hi, bus.result_lo}, 64'h0000_0000_0000_000F);
        bus.req = 1'b0;
        @(negedge clk);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        wait_valid();
        chk("dir_max", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFE_0000_0001);
        bus.req = 1'b0;
        @(negedge clk);

        issue(32'd7, 32'd6, 1'b0, 0);
        wait_valid();
        t1 = cyc;
        chk("b2b_first", {bus.result_hi, bus.result_lo}, 64'd42);
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 1);
        wait_valid();
        t2 = cyc;
        chk("b2b_second", {bus.result_hi, bus.result_lo}, 64'h0000_0001_0000_0000);
        chk("b2b_gap", 64'(t2 - t1), 64'd34);
        last = 64'h0000_0001_0000_0000;
        bus.req = 1'b0;
        @(negedge clk);

        // Flush at BUSY cycle 5: op is abandoned, so nothing is pushed.
        bus.req = 1'b1;
        bus.a   = $urandom;
        bus.b   = $urandom;
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        bus.req   = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_stall", 64'(bus.stall), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hold", {bus.result_hi, bus.result_lo}, last);

        // Asynchronous reset in BUSY cycle 10.
        issue($urandom, $urandom, 1'b0, 0);
        repeat (10) @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 1'b0;
        #1;
        chk("async_reset", {bus.stall, bus.valid, bus.result_hi, bus.result_lo}, 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'd9, 32'd11, 1'b0, 0);
        wait_valid();
        bus.req = 1'b0;
        @(negedge clk);

`ifdef COBRA_MUL_SIGNED_EN
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 0);
        wait_valid();
        chk("dir_signed", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        bus.req = 1'b0;
        @(negedge clk);
`endif

        b2b = 0;
        for (int i = 0; i < 24; i++) begin
`ifdef COBRA_MUL_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`else
            sgn = 1'b0;
`endif
            issue(pick(), pick(), sgn, b2b);
            wait_valid();
            b2b = int'($urandom_range(0, 1));
            if (b2b == 0) begin
                bus.req = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
